// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch/decode front end.
// Holds the phase encodings, instruction-class codes, PC step sizes and the decoded-field record.
package cpu_pkg;

  localparam logic [1:0] FETCH = 2'b00;
  localparam logic [1:0] READ  = 2'b01;
  localparam logic [1:0] EXEC  = 2'b10;
  localparam logic [1:0] WRITE = 2'b11;

  localparam logic [1:0] DP    = 2'b00;
  localparam logic [1:0] LS    = 2'b01;
  localparam logic [1:0] UNDEF = 2'b11;
  localparam logic [2:0] BR    = 3'b101;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] PC_PIPE = 32'd8;

  typedef struct packed {
    logic [3:0]  cond;
    logic [3:0]  op;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [11:0] operand;
    logic [23:0] offset;
    logic        b;
    logic        l;
    logic        t;
    logic        s;
    logic        ldr;
    logic        str;
    logic        p;
    logic        u;
    logic        bit_f;
    logic        w;
    logic        undef;
  } dec_t;

  // Word offset of a branch, sign-extended and scaled to a byte displacement.
  function automatic logic [31:0] branch_disp(input logic [23:0] off);
    return {{6{off[23]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational field extraction from the instruction register.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  // Class-dependent flags; fields that exist in every format are passed through unconditionally.
  always_comb begin
    dec         = '0;
    dec.cond    = instr[31:28];
    dec.offset  = instr[23:0];
    dec.rn      = instr[19:16];
    dec.rd      = instr[15:12];
    dec.operand = instr[11:0];
    dec.rm      = instr[3:0];
    case (instr[27:26])
      DP: begin
        dec.t  = instr[25];
        dec.op = instr[24:21];
        dec.s  = instr[20];
      end
      LS: begin
        dec.p     = instr[24];
        dec.u     = instr[23];
        dec.bit_f = instr[22];
        dec.w     = instr[21];
        dec.ldr   = instr[20];
        dec.str   = ~instr[20];
      end
      UNDEF: begin
        dec.undef = 1'b1;
      end
      default: begin
        if (instr[27:25] == BR) begin
          dec.b = 1'b1;
          dec.l = instr[24];
        end else begin
          dec.b = 1'b0;
          dec.l = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Four-phase fetch/decode front end: phase counter, program counter and instruction register,
// with field extraction delegated to instr_decoder.
module instr_fetch_decode
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        bf,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [1:0]  state,
  output logic [3:0]  cond,
  output logic [3:0]  op,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [3:0]  rm,
  output logic [11:0] operand,
  output logic [23:0] offset,
  output logic        b,
  output logic        l,
  output logic        t,
  output logic        s,
  output logic        ldr,
  output logic        str,
  output logic        p,
  output logic        u,
  output logic        bit_f,
  output logic        w,
  output logic        valid,
  output logic        undef
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        valid_q, valid_d;
  dec_t        dec;

  // Next-state: advance one phase per unstalled clock; capture on leaving FETCH, retarget on leaving WRITE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    if (!stall) begin
      state_d = state_q + 2'd1;
      case (state_q)
        FETCH: begin
          ir_d    = imem_data;
          valid_d = 1'b1;
        end
        WRITE: begin
          if (bf) begin
            pc_d = pc_q + PC_PIPE + branch_disp(ir_q[23:0]);
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
        default: begin
          pc_d = pc_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Architectural state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= 32'h0000_0000;
      ir_q    <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  instr_decoder u_decoder (
    .instr (ir_q),
    .dec   (dec)
  );

  // The read strobe is gated by rst_n so it drops immediately while reset is held in FETCH.
  assign imem_rd   = rst_n & (state_q == FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign state     = state_q;
  assign valid     = valid_q;

  assign cond    = dec.cond;
  assign op      = dec.op;
  assign rn      = dec.rn;
  assign rd      = dec.rd;
  assign rm      = dec.rm;
  assign operand = dec.operand;
  assign offset  = dec.offset;
  assign b       = dec.b;
  assign l       = dec.l;
  assign t       = dec.t;
  assign s       = dec.s;
  assign ldr     = dec.ldr;
  assign str     = dec.str;
  assign p       = dec.p;
  assign u       = dec.u;
  assign bit_f   = dec.bit_f;
  assign w       = dec.w;
  assign undef   = dec.undef;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: directed instructions push expected pc/fields,
// a monitor pops and compares on each fresh entry into READ.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n, stall, bf;
  logic [31:0] imem_data, imem_addr, pc;
  logic        imem_rd, valid, undef;
  logic [1:0]  state;
  logic [3:0]  cond, op, rn, rd, rm;
  logic [11:0] operand;
  logic [23:0] offset;
  logic        b, l, t, s, ldr, str, p, u, bit_f, w;

  always #5 clk = ~clk;

  instr_fetch_decode dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bf(bf),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .pc(pc), .state(state),
    .cond(cond), .op(op), .rn(rn), .rd(rd), .rm(rm),
    .operand(operand), .offset(offset),
    .b(b), .l(l), .t(t), .s(s), .ldr(ldr), .str(str),
    .p(p), .u(u), .bit_f(bit_f), .w(w),
    .valid(valid), .undef(undef)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [66:0] f;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [66:0] dut_f;
  assign dut_f = {cond, op, rn, rd, rm, operand, offset,
                  b, l, t, s, ldr, str, p, u, bit_f, w, undef};

  // flags = {b, l, t, s, ldr, str, p, u, bit, w, undef}
  function automatic logic [66:0] ef(input logic [3:0] c, input logic [3:0] o,
                                     input logic [3:0] n, input logic [3:0] d,
                                     input logic [3:0] m, input logic [11:0] opd,
                                     input logic [23:0] off, input logic [10:0] flags);
    return {c, o, n, d, m, opd, off, flags};
  endfunction

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each newly decoded instruction against the oldest expectation.
  logic [1:0] prev_state = 2'b00;
  always @(negedge clk) begin
    if (rst_n && valid && state == 2'b01 && prev_state != 2'b01) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: decode at pc %h with empty scoreboard", pc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_pc"}, pc, mon_e.pc);
        check({mon_e.name, "_fields"}, dut_f, mon_e.f);
        check({mon_e.name, "_rd_low"}, imem_rd, 1'b0);
      end
    end
    prev_state <= state;
  end

  // Entered at a negedge with the DUT in FETCH; leaves at the next FETCH negedge.
  task automatic run_instr(input string name, input logic [31:0] word, input logic [31:0] exp_pc,
                           input logic [66:0] exp_f, input logic bf_val, input logic do_stall);
    imem_data = word;
    bf        = 1'b0;
    stall     = 1'b0;
    #1;
    check({name, "_fetch_rd"}, imem_rd, 1'b1);
    check({name, "_fetch_addr"}, imem_addr, exp_pc);
    sb.push_back('{pc: exp_pc, f: exp_f, name: name});
    @(negedge clk);
    imem_data = 32'hFFFF_FFFF;
    bf        = 1'b1;
    @(negedge clk);
    if (do_stall) begin
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
        bf = ~bf;
        @(negedge clk);
        check({name, "_stall_state"}, state, 2'b10);
        check({name, "_stall_pc"}, pc, exp_pc);
        check({name, "_stall_fields"}, dut_f, exp_f);
      end
      stall = 1'b0;
      bf    = 1'b1;
    end
    @(negedge clk);
    check({name, "_write_state"}, state, 2'b11);
    bf = bf_val;
    @(negedge clk);
    bf = 1'b0;
  endtask

  localparam logic [66:0] ZERO_F = 67'd0;

  initial begin
    rst_n     = 1'b0;
    stall     = 1'b0;
    bf        = 1'b0;
    imem_data = 32'hE284_4001;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_state", state, 2'b00);
    check("rst_valid", valid, 1'b0);
    check("rst_rd", imem_rd, 1'b0);
    check("rst_fields", dut_f, ZERO_F);
    rst_n = 1'b1;

    run_instr("dp_add",   32'hE284_4001, 32'h0000_0000,
              ef(4'hE, 4'h4, 4'h4, 4'h4, 4'h1, 12'h001, 24'h844001, 11'b00100000000), 1'b0, 1'b0);
    run_instr("ldr",      32'hE591_2004, 32'h0000_0004,
              ef(4'hE, 4'h0, 4'h1, 4'h2, 4'h4, 12'h004, 24'h912004, 11'b00001011000), 1'b0, 1'b0);
    run_instr("dp_adds",  32'hE091_2003, 32'h0000_0008,
              ef(4'hE, 4'h4, 4'h1, 4'h2, 4'h3, 12'h003, 24'h912003, 11'b00010000000), 1'b0, 1'b0);
    run_instr("undef",    32'hEC12_3456, 32'h0000_000C,
              ef(4'hE, 4'h0, 4'h2, 4'h3, 4'h6, 12'h456, 24'h123456, 11'b00000000001), 1'b0, 1'b0);
    run_instr("bl",       32'hEB00_382C, 32'h0000_0010,
              ef(4'hE, 4'h0, 4'h0, 4'h3, 4'hC, 12'h82C, 24'h00382C, 11'b11000000000), 1'b0, 1'b0);
    run_instr("b_fwd",    32'hEA00_0039, 32'h0000_0014,
              ef(4'hE, 4'h0, 4'h0, 4'h0, 4'h9, 12'h039, 24'h000039, 11'b10000000000), 1'b1, 1'b0);
    run_instr("b_self",   32'hEAFF_FFFE, 32'h0000_0100,
              ef(4'hE, 4'h0, 4'hF, 4'hF, 4'hE, 12'hFFE, 24'hFFFFFE, 11'b10000000000), 1'b1, 1'b0);
    run_instr("b_stall",  32'hEAFF_FFFE, 32'h0000_0100,
              ef(4'hE, 4'h0, 4'hF, 4'hF, 4'hE, 12'hFFE, 24'hFFFFFE, 11'b10000000000), 1'b0, 1'b1);

    // Abort an instruction with an asynchronous reset in EXEC, between clock edges.
    imem_data = 32'hE591_2004;
    #1;
    check("abort_fetch_addr", imem_addr, 32'h0000_0104);
    sb.push_back('{pc: 32'h0000_0104,
                   f: ef(4'hE, 4'h0, 4'h1, 4'h2, 4'h4, 12'h004, 24'h912004, 11'b00001011000),
                   name: "abort"});
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_state", state, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_state", state, 2'b00);
    check("async_valid", valid, 1'b0);
    check("async_rd", imem_rd, 1'b0);
    check("async_fields", dut_f, ZERO_F);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("b_far",    32'hEA00_08AE, 32'h0000_0000,
              ef(4'hE, 4'h0, 4'h0, 4'h0, 4'hE, 12'h8AE, 24'h0008AE, 11'b10000000000), 1'b1, 1'b0);
    run_instr("after_far", 32'hEB00_382C, 32'h0000_22C0,
              ef(4'hE, 4'h0, 4'h0, 4'h3, 4'hC, 12'h82C, 24'h00382C, 11'b11000000000), 1'b0, 1'b0);

    rst_n = 1'b0;
    #1;
    check("rst2_pc", pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("b_far_nt", 32'hEA00_08AE, 32'h0000_0000,
              ef(4'hE, 4'h0, 4'h0, 4'h0, 4'hE, 12'h8AE, 24'h0008AE, 11'b10000000000), 1'b0, 1'b0);
    run_instr("b_back",   32'hEAFF_FFFC, 32'h0000_0004,
              ef(4'hE, 4'h0, 4'hF, 4'hF, 4'hC, 12'hFFC, 24'hFFFFFC, 11'b10000000000), 1'b1, 1'b0);
    run_instr("top_addr", 32'hE284_4001, 32'hFFFF_FFFC,
              ef(4'hE, 4'h4, 4'h4, 4'h4, 4'h1, 12'h001, 24'h844001, 11'b00100000000), 1'b0, 1'b0);
    run_instr("wrapped",  32'hE591_2004, 32'h0000_0000,
              ef(4'hE, 4'h0, 4'h1, 4'h2, 4'h4, 12'h004, 24'h912004, 11'b00001011000), 1'b0, 1'b0);

    stall = 1'b1;
    repeat (2) @(negedge clk);
    check("final_pc", pc, 32'h0000_0004);
    check("final_state", state, 2'b00);
    check("sb_drained", sb.size(), 67'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
